alu_issue_arbiter: RTL and testbench

- Round-robin arbiter sitting between the NUM_REQ operand-collector (OC) units and the single shared ALU.
- Each cycle it grants at most one ready OC entry, drives the ALU valid and operand-mux select, and stalls issue when the CDB back-pressures.
- It serialises branches per warp: after a BEQ/BLT is issued for a warp, further issue from that warp is blocked until the ALU reports the branch outcome to SIMT.

---
 rtl/alu_arb_pkg.sv | 34 +++
 rtl/alu_issue_arbiter_pick.sv | 27 ++
 rtl/alu_issue_arbiter.sv | 116 +++++++++++
 tb/tb_alu_issue_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU issue arbiter and later CDB arbiter.
package alu_arb_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int NUM_WARP_DEF = 8;
    localparam int WID_W_DEF    = 3;
    localparam int PICK_MAX     = 8;

    function automatic int log2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Scalar reference scan: one-hot winner, first set bit at or after ptr.
    function automatic logic [PICK_MAX-1:0] rr_pick(
        input logic [PICK_MAX-1:0] req_vec,
        input int                  n,
        input int                  ptr
    );
        logic [PICK_MAX-1:0] g;
        logic                found;
        int                  idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < PICK_MAX; k++) begin
            idx = (ptr + k) % n;
            if (k < n && !found && req_vec[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_issue_arbiter_pick.sv
// Combinational round-robin pick: rotate by ptr, take lowest set bit, unrotate.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] gnt2;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;

    always_comb begin
        req2 = {req, req} >> ptr;
        rot  = req2[N-1:0];
        pick = '0;
        for (int i = 0; i < N; i++) begin
            if (rot[i] && pick == '0) pick[i] = 1'b1;
        end
        gnt2  = {pick, pick} << ptr;
        grant = gnt2[2*N-1:N];
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin OC->ALU issue arbiter with per-warp branch serialisation.
// Optional saturating perf counters under ALU_ARB_PERF_EN.
module alu_issue_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int NUM_WARP = NUM_WARP_DEF,
    parameter int WID_W    = WID_W_DEF,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = log2w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       Req_OC_Arb,
    input  logic [NUM_REQ*WID_W-1:0] WarpID_OC_Arb,
    input  logic [NUM_REQ-1:0]       Branch_OC_Arb,
    input  logic                     Stall_CDB_Arb,
    input  logic                     Br_ALU_Arb,
    input  logic [WID_W-1:0]         BrWarpID_ALU_Arb,
    output logic [NUM_REQ-1:0]       Grant_Arb_OC,
    output logic                     Valid_Arb_ALU,
    output logic [SEL_W-1:0]         Sel_Arb_ALU,
    output logic [NUM_WARP-1:0]      BrPending_Arb,
    output logic [CNT_W-1:0]         GrantCnt_Arb,
    output logic [CNT_W-1:0]         StallCnt_Arb
);

    logic [SEL_W-1:0]    rr_ptr;
    logic [NUM_WARP-1:0] br_pend;
    logic [NUM_WARP-1:0] br_pend_nxt;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  grant;
    logic [SEL_W-1:0]    sel;
    logic                win_br;
    logic [WID_W-1:0]    win_warp;
    logic                issue_ok;

    // Grant is gated by rst so outputs read idle while reset is held.
    assign issue_ok = rst & ~Stall_CDB_Arb;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = Req_OC_Arb[i] & issue_ok
                    & ~br_pend[WarpID_OC_Arb[i*WID_W +: WID_W]];
        end
    end

    rr_priority_pick #(
        .N  (NUM_REQ),
        .PW (SEL_W)
    ) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        sel      = '0;
        win_br   = 1'b0;
        win_warp = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel      = SEL_W'(i);
                win_br   = Branch_OC_Arb[i];
                win_warp = WarpID_OC_Arb[i*WID_W +: WID_W];
            end
        end
    end

    // Clear first, then set, so a same-warp set wins.
    always_comb begin
        br_pend_nxt = br_pend;
        if (Br_ALU_Arb) br_pend_nxt[BrWarpID_ALU_Arb] = 1'b0;
        if (Valid_Arb_ALU && win_br) br_pend_nxt[win_warp] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            br_pend <= '0;
        end else begin
            br_pend <= br_pend_nxt;
            if (Valid_Arb_ALU) rr_ptr <= sel + SEL_W'(1);
        end
    end

    assign Grant_Arb_OC  = grant;
    assign Valid_Arb_ALU = |grant;
    assign Sel_Arb_ALU   = sel;
    assign BrPending_Arb = br_pend;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] grant_cnt;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (Valid_Arb_ALU && grant_cnt != '1)
                grant_cnt <= grant_cnt + CNT_W'(1);
            if (|Req_OC_Arb && !Valid_Arb_ALU && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign GrantCnt_Arb = grant_cnt;
    assign StallCnt_Arb = stall_cnt;
`else
    assign GrantCnt_Arb = '0;
    assign StallCnt_Arb = '0;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: fairness, branch block, stall,
// async reset and (with ALU_ARB_PERF_EN) saturating perf counters.
module tb_alu_issue_arbiter;

    localparam int NR = 4;
    localparam int NW = 8;
    localparam int WW = 3;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*WW-1:0] wid;
    logic [NR-1:0] br_req;
    logic          stall;
    logic          br;
    logic [WW-1:0] br_wid;
    logic [NR-1:0] gnt;
    logic          vld;
    logic [1:0]    sel;
    logic [NW-1:0] pend;
    logic [CW-1:0] gcnt;
    logic [CW-1:0] scnt;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_arbiter #(
        .NUM_REQ  (NR),
        .NUM_WARP (NW),
        .WID_W    (WW),
        .CNT_W    (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Req_OC_Arb       (req),
        .WarpID_OC_Arb    (wid),
        .Branch_OC_Arb    (br_req),
        .Stall_CDB_Arb    (stall),
        .Br_ALU_Arb       (br),
        .BrWarpID_ALU_Arb (br_wid),
        .Grant_Arb_OC     (gnt),
        .Valid_Arb_ALU    (vld),
        .Sel_Arb_ALU      (sel),
        .BrPending_Arb    (pend),
        .GrantCnt_Arb     (gcnt),
        .StallCnt_Arb     (scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_w(input logic [WW-1:0] a, input logic [WW-1:0] b,
                         input logic [WW-1:0] c, input logic [WW-1:0] d);
        wid = {d, c, b, a};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eg1, es1, eg2, es2;
`ifdef ALU_ARB_PERF_EN
        eg1 = 10; es1 = 4; eg2 = 15; es2 = 15;
`else
        eg1 = 0; es1 = 0; eg2 = 0; es2 = 0;
`endif
        rst = 1'b0; req = '0; br_req = '0; stall = 1'b0;
        br = 1'b0; br_wid = '0; wid = '0;
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_vld", vld, 0);
        check("rst_sel", sel, 0);
        check("rst_pend", pend, 0);
        check("rst_gcnt", gcnt, 0);
        check("rst_scnt", scnt, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // fairness
        req = 4'b1111; set_w(0, 1, 2, 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("fair_gnt", gnt, 1 << (c % 4));
            check("fair_sel", sel, c % 4);
            step();
        end

        // branch block, rr_ptr=1
        req = 4'b0010; br_req = 4'b0010; set_w(0, 5, 0, 0);
        @(negedge clk);
        check("br_issue", gnt, 4'b0010);
        step();
        check("br_pend_set", pend, 8'h20);
        req = 4'b1100; br_req = '0; set_w(0, 5, 5, 2);
        br = 1'b1; br_wid = 3'd5;
        @(negedge clk);
        check("br_block", gnt, 4'b1000);
        check("br_nobypass", pend, 8'h20);
        step();
        br = 1'b0; req = 4'b0100;
        check("br_pend_clr", pend, 0);
        @(negedge clk);
        check("br_unblock", gnt, 4'b0100);
        step();

        // same-warp set and clear: set wins; rr_ptr=3
        req = 4'b0001; br_req = 4'b0001; set_w(4, 0, 0, 0);
        br = 1'b1; br_wid = 3'd4;
        @(negedge clk);
        check("setwin_gnt", gnt, 4'b0001);
        step();
        check("setwin_pend", pend, 8'h10);
        req = '0; br_req = '0;
        step();
        check("clr4_pend", pend, 0);
        br_wid = 3'd7;
        step();
        check("clr_noop", pend, 0);
        br = 1'b0;

        // stall, rr_ptr=1
        req = 4'b0110; set_w(0, 1, 2, 0); stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_gnt", gnt, 0);
            check("stall_vld", vld, 0);
            check("stall_sel", sel, 0);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_rel1", gnt, 4'b0010);
        step();
        @(negedge clk);
        check("stall_rel2", gnt, 4'b0100);
        step();

        // resolve during stall
        req = 4'b0001; br_req = 4'b0001; set_w(3, 0, 0, 0);
        @(negedge clk);
        check("rs_issue", gnt, 4'b0001);
        step();
        check("rs_pend", pend, 8'h08);
        br_req = '0; stall = 1'b1; br = 1'b1; br_wid = 3'd3;
        @(negedge clk);
        check("rs_stall_gnt", gnt, 0);
        step();
        stall = 1'b0; br = 1'b0;
        check("rs_pend_clr", pend, 0);
        @(negedge clk);
        check("rs_regrant", gnt, 4'b0001);
        step();

        // async reset with pend=8'h21, rr_ptr=2
        req = 4'b0001; br_req = 4'b0001; set_w(0, 5, 6, 7);
        step();
        req = 4'b0010; br_req = 4'b0010;
        step();
        check("ar_pend", pend, 8'h21);
        req = 4'b1111; br_req = '0;
        @(negedge clk);
        check("ar_pre_gnt", gnt, 4'b0100);
        #2;
        rst = 1'b0;
        #1;
        check("ar_pend0", pend, 0);
        check("ar_gnt0", gnt, 0);
        check("ar_vld0", vld, 0);
        step();
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("ar_post_gnt", gnt, 4'b0001);
        check("ar_post_sel", sel, 0);
        step();

        // perf counters, fresh reset
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req = 4'b0001; set_w(0, 0, 0, 0);
        for (int c = 0; c < 10; c++) step();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("perf_gcnt", gcnt, eg1);
        check("perf_scnt", scnt, es1);
        stall = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check("perf_gsat", gcnt, eg2);
        stall = 1'b1;
        for (int c = 0; c < 12; c++) step();
        check("perf_ssat", scnt, es2);
        stall = 1'b0; req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
